// File: rtl/minmax_tracker.sv
// minmax_tracker: running unsigned minimum/maximum over a burst of samples.
// A burst of len samples arrives over a valid/ready handshake. The block
// tracks the smallest and largest value, and the index where each first
// appeared. Ties never update, so the earliest index wins. Results hold
// until the next accepted start.
module minmax_tracker #(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [CNTWIDTH-1:0]  len,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] min_val,
  output logic [DATAWIDTH-1:0] max_val,
  output logic [CNTWIDTH-1:0]  min_idx,
  output logic [CNTWIDTH-1:0]  max_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNTWIDTH-1:0]  len_q;
  logic [CNTWIDTH-1:0]  count;
  logic                 accept;
  logic                 last_run;

  // Unsigned strict-less / strict-greater, matching the upstream comparator.
  function automatic logic u_lt(input logic [DATAWIDTH-1:0] a,
                                input logic [DATAWIDTH-1:0] b);
    return a < b;
  endfunction

  function automatic logic u_gt(input logic [DATAWIDTH-1:0] a,
                                input logic [DATAWIDTH-1:0] b);
    return a > b;
  endfunction

  assign accept   = in_valid && in_ready;
  // The sample accepted in RUN with count == len-1 is the last one of the burst.
  assign last_run = (count == (len_q - CNTWIDTH'(1)));

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : FIRST;
      end
      FIRST: begin
        if (accept) state_nxt = (len_q == CNTWIDTH'(1)) ? DONE : RUN;
      end
      RUN: begin
        if (accept && last_run) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs, decoded straight from the state register
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      FIRST, RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Burst length, sample counter, running min/max with indices, result flag
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      len_q        <= '0;
      count        <= '0;
      min_val      <= '0;
      max_val      <= '0;
      min_idx      <= '0;
      max_idx      <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q        <= len;
            count        <= '0;
            result_valid <= 1'b0;
          end
        end
        FIRST: begin
          if (accept) begin
            min_val <= in_data;
            max_val <= in_data;
            min_idx <= '0;
            max_idx <= '0;
            count   <= CNTWIDTH'(1);
          end
        end
        RUN: begin
          if (accept) begin
            if (u_lt(in_data, min_val)) begin
              min_val <= in_data;
              min_idx <= count;
            end
            if (u_gt(in_data, max_val)) begin
              max_val <= in_data;
              max_idx <= count;
            end
            count <= count + CNTWIDTH'(1);
          end
        end
        DONE: begin
          // An empty burst leaves result_valid low.
          result_valid <= (len_q != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed testbench for minmax_tracker. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_minmax_tracker;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic [CW-1:0] len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] min_val;
  logic [DW-1:0] max_val;
  logic [CW-1:0] min_idx;
  logic [CW-1:0] max_idx;
  logic          busy;
  logic          done;
  logic          result_valid;

  int total = 0;
  int bad   = 0;

  minmax_tracker #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .min_val(min_val), .max_val(max_val), .min_idx(min_idx), .max_idx(max_idx),
    .busy(busy), .done(done), .result_valid(result_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    Rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    #1;
    total++;
    if ({in_ready, busy, done, result_valid, min_val, max_val, min_idx, max_idx} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%0b busy=%0b done=%0b rv=%0b min=%0h max=%0h mi=%0d xi=%0d, want all 0",
               in_ready, busy, done, result_valid, min_val, max_val, min_idx, max_idx);
    end
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    total++;
    if ({in_ready, busy, done, result_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_reset: got rdy=%0b busy=%0b done=%0b rv=%0b, want 0000",
               in_ready, busy, done, result_valid);
    end
  endtask

  // len=4: 5,3,9,3 back to back
  task automatic test_back_to_back();
    logic [DW-1:0] s [4];
    s[0] = 8'd5; s[1] = 8'd3; s[2] = 8'd9; s[3] = 8'd3;
    start = 1'b1; len = 8'd4;
    @(negedge Clk);
    start = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first_state: got rdy=%0b busy=%0b done=%0b, want 1 1 0", in_ready, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = s[i];
      @(negedge Clk);
      if (i < 3) begin
        total++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_mid_%0d: got done=%0b rdy=%0b, want 0 1", i, done, in_ready);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_pulse: got done=%0b rdy=%0b busy=%0b, want 1 0 0", done, in_ready, busy);
    end
    total++;
    if (min_val !== 8'd3 || min_idx !== 8'd1 || max_val !== 8'd9 || max_idx !== 8'd2) begin
      bad++;
      $display("FAIL b2b_result: got min=%0d@%0d max=%0d@%0d, want 3@1 9@2", min_val, min_idx, max_val, max_idx);
    end
    @(negedge Clk);
    total++;
    if (done !== 1'b0 || result_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_after: got done=%0b rv=%0b, want 0 1", done, result_valid);
    end
  endtask

  // len=1 single sample 0xAA
  task automatic test_single();
    start = 1'b1; len = 8'd1;
    @(negedge Clk);
    start = 1'b0;
    total++;
    if (result_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_rv_drop: got rv=%0b, want 0", result_valid);
    end
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge Clk);
    in_valid = 1'b0;
    total++;
    if (done !== 1'b1 || min_val !== 8'hAA || max_val !== 8'hAA || min_idx !== 8'd0 || max_idx !== 8'd0) begin
      bad++;
      $display("FAIL single_result: got done=%0b min=%0h@%0d max=%0h@%0d, want 1 aa@0 aa@0",
               done, min_val, min_idx, max_val, max_idx);
    end
    @(negedge Clk);
    total++;
    if (result_valid !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_after: got rv=%0b done=%0b, want 1 0", result_valid, done);
    end
  endtask

  // len=0: immediate done, no sample accepted, values untouched
  task automatic test_empty();
    start = 1'b1; len = 8'd0;
    in_valid = 1'b1; in_data = 8'h11;
    @(negedge Clk);
    start = 1'b0;
    total++;
    if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL empty_done: got done=%0b rdy=%0b busy=%0b rv=%0b, want 1 0 0 0",
               done, in_ready, busy, result_valid);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    total++;
    if (done !== 1'b0 || result_valid !== 1'b0 || in_ready !== 1'b0 || min_val !== 8'hAA || max_val !== 8'hAA) begin
      bad++;
      $display("FAIL empty_after: got done=%0b rv=%0b rdy=%0b min=%0h max=%0h, want 0 0 0 aa aa",
               done, result_valid, in_ready, min_val, max_val);
    end
  endtask

  // len=3: 7,7,7 with two idle cycles between samples
  task automatic test_gaps();
    start = 1'b1; len = 8'd3;
    @(negedge Clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'd7;
      @(negedge Clk);
      in_valid = 1'b0; in_data = 8'd0;
      if (i < 2) begin
        @(negedge Clk); @(negedge Clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || min_val !== 8'd7 || max_val !== 8'd7) begin
          bad++;
          $display("FAIL gap_%0d: got done=%0b busy=%0b min=%0d max=%0d, want 0 1 7 7",
                   i, done, busy, min_val, max_val);
        end
      end
    end
    total++;
    if (done !== 1'b1 || min_idx !== 8'd0 || max_idx !== 8'd0 || min_val !== 8'd7) begin
      bad++;
      $display("FAIL gap_result: got done=%0b min=%0d@%0d max@%0d, want 1 7@0 @0",
               done, min_val, min_idx, max_idx);
    end
    @(negedge Clk);
  endtask

  // len=4: 0x80,0x7F,0xFF,0x00 -- ordering must be unsigned
  task automatic test_unsigned();
    logic [DW-1:0] s [4];
    s[0] = 8'h80; s[1] = 8'h7F; s[2] = 8'hFF; s[3] = 8'h00;
    start = 1'b1; len = 8'd4;
    @(negedge Clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = s[i];
      @(negedge Clk);
      if (i == 1) begin
        total++;
        if (min_val !== 8'h7F || min_idx !== 8'd1 || max_val !== 8'h80 || max_idx !== 8'd0) begin
          bad++;
          $display("FAIL unsigned_mid: got min=%0h@%0d max=%0h@%0d, want 7f@1 80@0",
                   min_val, min_idx, max_val, max_idx);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (done !== 1'b1 || max_val !== 8'hFF || max_idx !== 8'd2 || min_val !== 8'h00 || min_idx !== 8'd3) begin
      bad++;
      $display("FAIL unsigned_result: got done=%0b min=%0h@%0d max=%0h@%0d, want 1 00@3 ff@2",
               done, min_val, min_idx, max_val, max_idx);
    end
    @(negedge Clk);
  endtask

  // start mid-RUN is ignored; async reset mid-RUN; then a clean burst
  task automatic test_mid_start_reset();
    start = 1'b1; len = 8'd4;
    @(negedge Clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'd10;
    @(negedge Clk);
    in_data = 8'd20;
    @(negedge Clk);
    in_valid = 1'b0; start = 1'b1; len = 8'd1;
    @(negedge Clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || min_val !== 8'd10 || max_val !== 8'd20) begin
      bad++;
      $display("FAIL ignore_start: got busy=%0b done=%0b min=%0d max=%0d, want 1 0 10 20",
               busy, done, min_val, max_val);
    end
    in_valid = 1'b1; in_data = 8'd5;
    @(negedge Clk);
    in_valid = 1'b0;
    total++;
    if (min_val !== 8'd5 || min_idx !== 8'd2 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL count_kept: got min=%0d@%0d done=%0b busy=%0b, want 5@2 0 1",
               min_val, min_idx, done, busy);
    end
    #2;
    Rst = 1'b1;
    #1;
    total++;
    if ({in_ready, busy, done, result_valid, min_val, max_val, min_idx, max_idx} !== '0) begin
      bad++;
      $display("FAIL async_reset: got rdy=%0b busy=%0b done=%0b rv=%0b min=%0h max=%0h mi=%0d xi=%0d, want all 0",
               in_ready, busy, done, result_valid, min_val, max_val, min_idx, max_idx);
    end
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    start = 1'b1; len = 8'd2;
    @(negedge Clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'd1;
    @(negedge Clk);
    in_data = 8'd2;
    @(negedge Clk);
    in_valid = 1'b0;
    total++;
    if (done !== 1'b1 || min_val !== 8'd1 || min_idx !== 8'd0 || max_val !== 8'd2 || max_idx !== 8'd1) begin
      bad++;
      $display("FAIL clean_burst: got done=%0b min=%0d@%0d max=%0d@%0d, want 1 1@0 2@1",
               done, min_val, min_idx, max_val, max_idx);
    end
    @(negedge Clk);
    total++;
    if (result_valid !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL clean_after: got rv=%0b done=%0b, want 1 0", result_valid, done);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_empty();
    test_gaps();
    test_unsigned();
    test_mid_start_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
- Sequential consumer of the comparator stage.
- Accepts a stream of unsigned DATAWIDTH samples through a valid/ready handshake.
- Keeps a running minimum and maximum, plus the index where each first occurred, using the same unsigned a>b / a<b / a==b rules as the comparator.
- Sits downstream of COMP in the datapath library and reports min/max over a programmable-length burst.

Parameters:
DATAWIDTH, 8, sample and min/max width (unsigned)
CNTWIDTH, 8, width of len, sample counter and index outputs

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous reset, active-high
start  input  1  begin a burst; sampled only in IDLE
len  input  CNTWIDTH  number of samples in the burst; latched on accepted start
in_valid  input  1  in_data valid
in_data  input  DATAWIDTH  sample (unsigned)
in_ready  output  1  block can accept a sample this cycle
min_val  output  DATAWIDTH  running/final minimum
max_val  output  DATAWIDTH  running/final maximum
min_idx  output  CNTWIDTH  index (0-based) of first occurrence of min_val
max_idx  output  CNTWIDTH  index (0-based) of first occurrence of max_val
busy  output  1  high in FIRST and RUN
done  output  1  one-cycle pulse at end of burst
result_valid  output  1  min/max outputs hold a completed non-empty burst; level signal

Behaviour:
- Interface: one clock, Clk. Reset Rst is asynchronous and active-high.
- Rst=1 (any time, including mid-burst):
  - state=IDLE.
  - All outputs 0 immediately (in_ready, busy, done, result_valid, min/max values and indices).
  - Internal count and latched len cleared.
- All state and outputs are registered. in_ready, busy and done decode directly from the state register.
- Handshake: a sample is accepted on a rising edge where in_valid=1 and in_ready=1. in_data is ignored otherwise.
- States:
  - IDLE:
    - in_ready=0.
    - start=1: latch len, clear result_valid, count=0.
    - len==0: go to DONE. len!=0: go to FIRST.
  - FIRST:
    - in_ready=1.
    - On accept: min_val=max_val=in_data, min_idx=max_idx=0, count=1.
    - len==1: go to DONE. Else go to RUN.
  - RUN:
    - in_ready=1.
    - On accept:
      - in_data<min_val: min_val=in_data, min_idx=count.
      - in_data>max_val: max_val=in_data, max_idx=count.
      - Equal values never update, so ties keep the earliest index.
      - count++.
    - Accept with count==len-1 (last sample): go to DONE.
  - DONE:
    - done=1 for exactly this one cycle; in_ready=0.
    - result_valid set to 1 if latched len!=0, else stays 0.
    - Unconditional go to IDLE.
- Timing:
  - min/max/idx updates are visible the cycle after the accepting edge.
  - done is high in the cycle after the last accepting edge.
  - For len=0, done is high in the cycle after the start edge.
- Results hold until the next accepted start.
  - If that start has len!=0, the value outputs hold until the FIRST accept.
  - result_valid drops at the start edge.
- start outside IDLE (FIRST/RUN/DONE) is ignored; it is not queued.
- Counter and index arithmetic is unsigned CNTWIDTH. The maximum burst is 2^CNTWIDTH-1 samples, so no wrap-around occurs.
- Comparisons are strictly unsigned: 0x80 > 0x7F.
- in_valid gaps in FIRST/RUN stall indefinitely. There is no timeout.

Test Plan:
1. Start with len=4, stream 5,3,9,3 back-to-back -> min_val=3, min_idx=1, max_val=9, max_idx=2; done one-cycle pulse the cycle after the 4th accept; result_valid=1 afterwards.
2. len=1, sample 0xAA -> min_val=max_val=0xAA, both idx=0, state skips RUN, done after one accept.
3. len=0 -> done pulses the cycle after start, in_ready never asserts, result_valid=0, values remain at prior/reset contents.
4. len=3, samples 7,7,7 with in_valid low for 2 cycles between each -> no accepts during gaps, min_idx=max_idx=0, done after 3rd accept.
5. len=4, samples 0x80,0x7F,0xFF,0x00 -> max_val=0xFF idx=2, min_val=0x00 idx=3 (unsigned ordering).
6. Assert start again mid-RUN (ignored, count unaffected), then assert Rst between clock edges mid-RUN -> all outputs 0 asynchronously, in_ready=0, next start runs a clean burst.
